// File: rtl/mulwide249857s_if.sv
// rtl/mulwide249857s_if.sv - request/result bundle for the wide Booth multiplier
interface mulwide249857s_if;
    logic               start;
    logic signed [17:0] inA;
    logic signed [17:0] inB;
    logic               busy;
    logic               done;
    logic               err;
    logic signed [34:0] outZ;

    modport master (
        output start, inA, inB,
        input  busy, done, err, outZ
    );

    modport slave (
        input  start, inA, inB,
        output busy, done, err, outZ
    );
endinterface

// File: rtl/mulwide249857s.sv
// rtl/mulwide249857s.sv - iterative signed radix-4 Booth multiplier, 18x18 -> 35 bits
module mulwide249857s #(
    parameter int Q = 249857
) (
    input  logic             clk,
    input  logic             rst,
    mulwide249857s_if.slave  bus
);
    localparam int W_IN  = 18;
    localparam int W_OUT = 35;
    localparam int W_ACC = W_OUT + 1;
    localparam int QH    = (Q - 1) / 2;

    localparam logic signed [W_IN-1:0] QH_POS = W_IN'(QH);
    localparam logic signed [W_IN-1:0] QH_NEG = -QH_POS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] K_LAST = 4'd8;

    logic [1:0]       state_q, state_d;
    logic [W_ACC-1:0] a_q, a_d;         // multiplicand, pre-shifted by 2k
    logic [W_IN-1:0]  b_q, b_d;         // multiplier, shifted right 2 per digit
    logic             bprev_q, bprev_d; // b[2k-1] of the current digit
    logic [3:0]       k_q, k_d;
    logic [W_ACC-1:0] acc_q, acc_d;
    logic [W_OUT-1:0] outz_q, outz_d;
    logic             err_q, err_d;

    logic             in_range;
    logic [W_ACC-1:0] pp;
    logic [W_ACC-1:0] acc_nxt;

    // Both operands must be centered residues in [-QH, +QH]
    always_comb begin
        in_range = (bus.inA >= QH_NEG) && (bus.inA <= QH_POS) &&
                   (bus.inB >= QH_NEG) && (bus.inB <= QH_POS);
    end

    // Booth digit selection from the lowest two multiplier bits plus the carried bit
    always_comb begin
        pp = '0;
        case ({b_q[1:0], bprev_q})
            3'b001, 3'b010: pp = a_q;
            3'b011:         pp = a_q << 1;
            3'b100:         pp = -(a_q << 1);
            3'b101, 3'b110: pp = -a_q;
            default:        pp = '0;
        endcase
        acc_nxt = acc_q + pp;
    end

    // Next-state: accept in IDLE/DONE, one digit per RUN cycle, single-cycle DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bprev_d = bprev_q;
        k_d     = k_q;
        acc_d   = acc_q;
        outz_d  = outz_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    a_d     = {{(W_ACC-W_IN){bus.inA[W_IN-1]}}, bus.inA};
                    b_d     = bus.inB;
                    bprev_d = 1'b0;
                    k_d     = '0;
                    acc_d   = '0;
                    if (in_range) begin
                        state_d = ST_RUN;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        outz_d  = '0;
                    end
                end
            end
            ST_RUN: begin
                acc_d   = acc_nxt;
                a_d     = a_q << 2;
                b_d     = {{2{b_q[W_IN-1]}}, b_q[W_IN-1:2]};
                bprev_d = b_q[1];
                k_d     = k_q + 4'd1;
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                    outz_d  = acc_nxt[W_OUT-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight product
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bprev_q <= 1'b0;
            k_q     <= '0;
            acc_q   <= '0;
            outz_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bprev_q <= bprev_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            outz_q  <= outz_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.err  = err_q;
    assign bus.outZ = outz_q;
endmodule
